// File: rtl/ex_issue_stage_pkg.sv
// Shared types and constants for the ID/EX issue stage.
// ALU function codes plus the registered control bundle.
package ex_pkg;

    localparam logic [3:0] ALU_SLL   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_ADD   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_NOR   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLLV  = 4'd9;
    localparam logic [3:0] ALU_SRLV  = 4'd10;
    localparam logic [3:0] ALU_SRAV  = 4'd11;
    localparam logic [3:0] ALU_PASSA = 4'd12;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic uses_rs;
        logic uses_rt;
        logic use_imm;
    } ex_ctrl_t;

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decoded-instruction bundle from ID into the issue stage.
// id_stall flows back to hold PC and IF/ID.
interface ex_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rs_val;
    logic [DATA_W-1:0] id_rt_val;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [4:0]        id_sa;
    logic [3:0]        id_alu_f;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_rs_val, id_rt_val, id_imm, id_use_imm,
        output id_sa, id_alu_f, id_dst,
        output id_reg_write, id_mem_read, id_mem_write,
        input  id_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_rs_val, id_rt_val, id_imm, id_use_imm,
        input  id_sa, id_alu_f, id_dst,
        input  id_reg_write, id_mem_read, id_mem_write,
        output id_stall
    );
endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// Per-operand forwarding selector: $zero, then MEM, then WB,
// else the value captured from the register file in ID.
module fwd_mux
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              i_uses,
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_reg_val,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic [DATA_W-1:0] i_mem_val,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_dst,
    input  logic [DATA_W-1:0] i_wb_val,
    output logic [DATA_W-1:0] o_val
);
    logic w_zero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_zero    = (i_src == REG_AW'(REG_ZERO));
    assign w_mem_hit = (FWD_EN != 0) && i_mem_we && (i_mem_dst == i_src);
    assign w_wb_hit  = (FWD_EN != 0) && i_wb_we && (i_wb_dst == i_src);

    always_comb begin
        o_val = i_reg_val;
        if (i_uses) begin
            if (w_zero)         o_val = '0;
            else if (w_mem_hit) o_val = i_mem_val;
            else if (w_wb_hit)  o_val = i_wb_val;
        end
    end
endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with load-use interlock and
// MEM/WB operand forwarding into the EX-stage ALU.
module ex_issue_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush,
    ex_issue_stage_if.slave   id_if,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_sa,
    output logic [3:0]        alu_f,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);
    ex_ctrl_t          r_ctrl;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dst;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_sa;
    logic [3:0]        r_f;

    logic              w_hit_rs;
    logic              w_hit_rt;
    logic              w_stall;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Only a load still in EX can't be forwarded in time.
    assign w_hit_rs = id_if.id_uses_rs && (id_if.id_rs == r_dst);
    assign w_hit_rt = id_if.id_uses_rt && (id_if.id_rt == r_dst);
    assign w_stall  = r_ctrl.valid && r_ctrl.mem_read
                   && (r_dst != REG_AW'(REG_ZERO))
                   && id_if.id_valid && !flush
                   && (w_hit_rs || w_hit_rt);
    assign w_bubble = flush || w_stall;

    assign id_if.id_stall = w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl   <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_dst    <= '0;
            r_rs_val <= '0;
            r_rt_val <= '0;
            r_imm    <= '0;
            r_sa     <= '0;
            r_f      <= ALU_SLL;
        end else if (!stall_in) begin
            if (w_bubble) begin
                r_ctrl   <= '0;
                r_rs     <= '0;
                r_rt     <= '0;
                r_dst    <= '0;
                r_rs_val <= '0;
                r_rt_val <= '0;
                r_imm    <= '0;
                r_sa     <= '0;
                r_f      <= ALU_SLL;
            end else begin
                r_ctrl.valid     <= id_if.id_valid;
                r_ctrl.reg_write <= id_if.id_valid && id_if.id_reg_write;
                r_ctrl.mem_read  <= id_if.id_valid && id_if.id_mem_read;
                r_ctrl.mem_write <= id_if.id_valid && id_if.id_mem_write;
                r_ctrl.uses_rs   <= id_if.id_uses_rs;
                r_ctrl.uses_rt   <= id_if.id_uses_rt;
                r_ctrl.use_imm   <= id_if.id_use_imm;
                r_rs     <= id_if.id_rs;
                r_rt     <= id_if.id_rt;
                r_dst    <= id_if.id_dst;
                r_rs_val <= id_if.id_rs_val;
                r_rt_val <= id_if.id_rt_val;
                r_imm    <= id_if.id_imm;
                r_sa     <= id_if.id_sa;
                r_f      <= id_if.id_alu_f;
            end
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs (
        .i_uses    (r_ctrl.uses_rs),
        .i_src     (r_rs),
        .i_reg_val (r_rs_val),
        .i_mem_we  (mem_reg_write),
        .i_mem_dst (mem_dst),
        .i_mem_val (mem_result),
        .i_wb_we   (wb_reg_write),
        .i_wb_dst  (wb_dst),
        .i_wb_val  (wb_result),
        .o_val     (w_fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rt (
        .i_uses    (r_ctrl.uses_rt),
        .i_src     (r_rt),
        .i_reg_val (r_rt_val),
        .i_mem_we  (mem_reg_write),
        .i_mem_dst (mem_dst),
        .i_mem_val (mem_result),
        .i_wb_we   (wb_reg_write),
        .i_wb_dst  (wb_dst),
        .i_wb_val  (wb_result),
        .o_val     (w_fwd_rt)
    );

    assign ex_valid      = r_ctrl.valid;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_dst        = r_dst;
    assign alu_sa        = r_sa;
    assign alu_f         = r_f;
    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_ctrl.use_imm ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
endmodule
